class_score_buffer: RTL and testbench
=====================================

# class_score_buffer

Collects the output-layer neuron scores of one inference, delivered one per cycle, and converts each to an 8-bit unsigned score. Packs them into the flat `NUM_CLASSES*8`-bit vector consumed by the argmax classifier stage directly downstream, with class i at bits [i*8+7 : i*8]. Holds each completed frame stable under a valid/ready handshake until the classifier side accepts it.

## Interface

**Parameters**
- `NUM_CLASSES`, default 10: scores per frame.
- `IN_W`, default 16: width of the signed neuron accumulator input.
- `SCORE_W`, default 8: packed score width. Fixed at 8 to match the classifier.

**Ports**
- `clk` — in, 1: single clock, rising edge.
- `rst_n` — in, 1: asynchronous, active-low reset.
- `in_valid` — in, 1: `in_score` is valid.
- `in_ready` — out, 1: buffer accepts a score this cycle.
- `in_score` — in, IN_W: signed neuron score, two's complement.
- `in_last` — in, 1: marks the final score of a frame.
- `out_valid` — out, 1: `out_array` holds a complete frame.
- `out_ready` — in, 1: downstream accepts the frame.
- `out_array` — out, NUM_CLASSES*SCORE_W: packed scores.
- `frame_err` — out, 1: sticky; `in_last` did not align with slot NUM_CLASSES-1.
- `err_clr` — in, 1: synchronous clear of `frame_err`.

## Operation

- Two states: FILL and HOLD. Reset state is FILL.
- A transfer is accepted when `in_valid && in_ready`.
- **FILL:**
  - `in_ready`=1, `out_valid`=0.
  - Each accepted score is converted and written to slot `wr_idx`, then `wr_idx` increments.
  - `wr_idx` counts 0..NUM_CLASSES-1 and is `$clog2(NUM_CLASSES)` bits wide.
- **FILL → HOLD** on the accept of either:
  - slot NUM_CLASSES-1, or
  - any score with `in_last`=1.
- **Early `in_last`** (accepted at slot k < NUM_CLASSES-1):
  - slots k+1..NUM_CLASSES-1 remain 0;
  - `frame_err` is set.
- **Missing `in_last`** (slot NUM_CLASSES-1 accepted with `in_last`=0):
  - `frame_err` is set;
  - the frame is still emitted.
- **HOLD:**
  - `in_ready`=0, `out_valid`=1.
  - `out_array` is stable and does not change while `out_valid`=1 and `out_ready`=0.
- **HOLD → FILL** on `out_valid && out_ready`:
  - all slots cleared to 0;
  - `wr_idx` set to 0.
- **`frame_err`:**
  - Set has priority over `err_clr` in the same cycle.
  - Otherwise `err_clr`=1 clears it next cycle.
- **Reset values:** `out_valid`=0, `in_ready`=1 (combinational from state), `out_array`=0, `frame_err`=0, `wr_idx`=0, state FILL.
- **Reset mid-frame:** the partial frame is discarded and all state returns to the reset values.

## Timing

- `out_valid` rises the cycle after the accept that ends the frame.
- Throughput: NUM_CLASSES+1 cycles per frame minimum.
  - NUM_CLASSES fill cycles plus one HOLD cycle, with `out_ready` held at 1.
- No combinational path from `out_ready` to `in_ready`.
  - `in_ready` depends on the state register only.
  - The cycle after the HOLD→FILL handshake, `in_ready`=1.
- `out_array` is driven directly from registers, with no output logic after the flops.
- Score conversion is combinational on `in_score` and is registered into the slot: one register stage in total.

## Configuration

- **`SCORE_RELU_EN` defined:** saturating ReLU quantization.
  - `in_score` < 0 → 0.
  - `in_score` > 255 → 255.
  - Otherwise `in_score[7:0]`.
- **`SCORE_RELU_EN` undefined:** plain truncation.
  - Slot receives `in_score[SCORE_W-1:0]`.
  - Sign and upper bits are ignored.
- Handshake, framing and error behaviour are identical in both builds.

## Structure

- Shared package `nn_pkg` holds:
  - `NN_NUM_CLASSES`=10 and `NN_SCORE_W`=8;
  - the state typedef `cls_buf_state_t` {FILL, HOLD}.
- One combinational sub-module, `score_quantize`:
  - ports: `IN_W`-bit signed input → `SCORE_W`-bit output;
  - contains the `SCORE_RELU_EN` logic, so it is reusable by other layer outputs.

## Test plan

- **Back-to-back frame:** `in_valid`=1 every cycle, scores 0..9 (value = 10·i), `in_last` on the 10th, `out_ready`=1 → `out_valid` one cycle after the 10th accept; `out_array[79:72]`=90, `[7:0]`=0; `frame_err`=0.
- **Backpressure:** `out_ready`=0 for 5 cycles in HOLD → `in_ready`=0 and `out_array` unchanged throughout; on the `out_ready` pulse the frame is consumed and `in_ready`=1 next cycle.
- **Early last:** `in_last` with the 4th score → `out_valid` next cycle, slots 4..9 = 0, `frame_err`=1; `err_clr` pulse → `frame_err`=0.
- **Quantization:**
  - With `SCORE_RELU_EN`: `in_score` = -5 → 0, 300 → 255, 77 → 77.
  - Without it: -5 (0xFFFB) → 0xFB, 300 (0x012C) → 0x2C.
- **Reset mid-frame:** assert `rst_n`=0 after 6 accepts → `out_array`=0, `out_valid`=0; a new full frame afterwards packs correctly from slot 0.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared constants and types for the neural-network output stage.
package nn_pkg;

  localparam int NN_NUM_CLASSES = 10;
  localparam int NN_SCORE_W     = 8;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } cls_buf_state_t;

endpackage

// File: rtl/score_quantize.sv
// Converts a signed neuron accumulator to an unsigned packed score.
// Build option: define SCORE_RELU_EN for saturating ReLU; otherwise plain truncation.
module score_quantize #(
  parameter int IN_W    = 16,
  parameter int SCORE_W = 8
) (
  input  logic signed [IN_W-1:0]    in_score,
  output logic        [SCORE_W-1:0] out_score
);

`ifdef SCORE_RELU_EN
  localparam logic signed [IN_W-1:0] SAT_MAX = IN_W'((1 << SCORE_W) - 1);

  // Clamp negatives to zero and large positives to the top code
  always_comb begin
    out_score = {SCORE_W{1'b0}};
    if (in_score < $signed({IN_W{1'b0}})) begin
      out_score = {SCORE_W{1'b0}};
    end else if (in_score > SAT_MAX) begin
      out_score = {SCORE_W{1'b1}};
    end else begin
      out_score = in_score[SCORE_W-1:0];
    end
  end
`else
  logic unused_upper_s;

  assign unused_upper_s = ^in_score[IN_W-1:SCORE_W];
  assign out_score      = in_score[SCORE_W-1:0];
`endif

endmodule

// File: rtl/class_score_buffer.sv
// Collects one frame of output-layer scores and holds it for the argmax stage.
// Build option: SCORE_RELU_EN selects saturating ReLU quantization in score_quantize.
module class_score_buffer
  import nn_pkg::*;
#(
  parameter int NUM_CLASSES = NN_NUM_CLASSES,
  parameter int IN_W        = 16,
  parameter int SCORE_W     = NN_SCORE_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [IN_W-1:0]         in_score,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_CLASSES*SCORE_W-1:0] out_array,
  output logic                           frame_err,
  input  logic                           err_clr
);

  localparam int IDX_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  cls_buf_state_t                   state_q, state_d;
  logic [IDX_W-1:0]                 wr_idx_q, wr_idx_d;
  logic [NUM_CLASSES*SCORE_W-1:0]   array_q, array_d;
  logic                             frame_err_q, frame_err_d;
  logic [SCORE_W-1:0]               quant_s;
  logic                             accept_s;
  logic                             err_set_s;

  score_quantize #(
    .IN_W    (IN_W),
    .SCORE_W (SCORE_W)
  ) u_quant (
    .in_score  (in_score),
    .out_score (quant_s)
  );

  // in_ready depends only on the state register, never on out_ready
  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == HOLD);
  assign out_array = array_q;
  assign frame_err = frame_err_q;
  assign accept_s  = in_valid && in_ready;

  // Next-state, slot write and framing-error detection
  always_comb begin
    state_d   = state_q;
    wr_idx_d  = wr_idx_q;
    array_d   = array_q;
    err_set_s = 1'b0;
    case (state_q)
      FILL: begin
        if (accept_s) begin
          array_d[wr_idx_q*SCORE_W +: SCORE_W] = quant_s;
          wr_idx_d = wr_idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
          if ((wr_idx_q == LAST_IDX) || in_last) begin
            state_d = HOLD;
          end else begin
            state_d = FILL;
          end
          // in_last must coincide exactly with the final slot
          err_set_s = (wr_idx_q == LAST_IDX) != in_last;
        end else begin
          state_d = FILL;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d  = FILL;
          wr_idx_d = {IDX_W{1'b0}};
          array_d  = {(NUM_CLASSES*SCORE_W){1'b0}};
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d  = FILL;
        wr_idx_d = {IDX_W{1'b0}};
        array_d  = {(NUM_CLASSES*SCORE_W){1'b0}};
      end
    endcase

    if (err_set_s) begin
      frame_err_d = 1'b1;
    end else if (err_clr) begin
      frame_err_d = 1'b0;
    end else begin
      frame_err_d = frame_err_q;
    end
  end

  // State, index, slot and error registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      wr_idx_q    <= {IDX_W{1'b0}};
      array_q     <= {(NUM_CLASSES*SCORE_W){1'b0}};
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      array_q     <= array_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_class_score_buffer.sv
// Directed self-checking bench for class_score_buffer (default 10 classes, 16-bit input).
module tb_class_score_buffer;

  localparam int NC = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_score = 16'h0000;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [79:0] out_array;
  logic        frame_err;
  logic        err_clr = 1'b0;

  int n_total = 0;
  int n_bad   = 0;
  logic [79:0] exp_arr;

  class_score_buffer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_score  (in_score),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_array (out_array),
    .frame_err (frame_err),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] s, input logic l);
    check("in_ready_before_push", {79'd0, in_ready}, 80'd1);
    in_valid = 1'b1;
    in_score = s;
    in_last  = l;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_score = 16'h0000;
  endtask

  initial begin
    // Reset values
    #2;
    check("rst_out_valid", {79'd0, out_valid}, 80'd0);
    check("rst_in_ready",  {79'd0, in_ready},  80'd1);
    check("rst_array",     out_array,          80'd0);
    check("rst_frame_err", {79'd0, frame_err}, 80'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Back-to-back frame, scores 10*i, out_ready held high
    out_ready = 1'b1;
    exp_arr = 80'd0;
    for (int i = 0; i < NC; i++) begin
      exp_arr[i*8 +: 8] = 8'(10 * i);
      push(16'(10 * i), (i == NC - 1));
      if (i < NC - 1) check("b2b_no_valid_mid", {79'd0, out_valid}, 80'd0);
    end
    check("b2b_out_valid", {79'd0, out_valid}, 80'd1);
    check("b2b_slot9", {72'd0, out_array[79:72]}, 80'd90);
    check("b2b_slot0", {72'd0, out_array[7:0]},   80'd0);
    check("b2b_array", out_array, exp_arr);
    check("b2b_err",   {79'd0, frame_err}, 80'd0);
    tick();
    check("b2b_consumed_valid", {79'd0, out_valid}, 80'd0);
    check("b2b_consumed_ready", {79'd0, in_ready},  80'd1);
    check("b2b_cleared",        out_array,          80'd0);

    // Backpressure: hold the frame for 5 cycles
    out_ready = 1'b0;
    exp_arr = 80'd0;
    for (int i = 0; i < NC; i++) begin
      exp_arr[i*8 +: 8] = 8'(i + 1);
      push(16'(i + 1), (i == NC - 1));
    end
    for (int c = 0; c < 5; c++) begin
      check("bp_in_ready", {79'd0, in_ready},  80'd0);
      check("bp_valid",    {79'd0, out_valid}, 80'd1);
      check("bp_array",    out_array,          exp_arr);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_ready_after", {79'd0, in_ready},  80'd1);
    check("bp_valid_after", {79'd0, out_valid}, 80'd0);

    // Early in_last on the 4th score
    exp_arr = 80'd0;
    for (int i = 0; i < 4; i++) begin
      exp_arr[i*8 +: 8] = 8'(20 + i);
      push(16'(20 + i), (i == 3));
    end
    check("early_valid", {79'd0, out_valid}, 80'd1);
    check("early_array", out_array, exp_arr);
    check("early_err",   {79'd0, frame_err}, 80'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("early_err_sticky", {79'd0, frame_err}, 80'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("early_err_cleared", {79'd0, frame_err}, 80'd0);

    // Missing in_last: frame still emitted, error set
    exp_arr = 80'd0;
    for (int i = 0; i < NC; i++) begin
      exp_arr[i*8 +: 8] = 8'(50 + i);
      push(16'(50 + i), 1'b0);
    end
    check("miss_valid", {79'd0, out_valid}, 80'd1);
    check("miss_array", out_array, exp_arr);
    check("miss_err",   {79'd0, frame_err}, 80'd1);
    // err_clr during an error-setting accept must lose; checked on next frame
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Quantization frame: -5, 300, 77, then zeros; err_clr held while last slot lacks in_last
    exp_arr = 80'd0;
`ifdef SCORE_RELU_EN
    exp_arr[7:0]   = 8'h00;
    exp_arr[15:8]  = 8'hFF;
`else
    exp_arr[7:0]   = 8'hFB;
    exp_arr[15:8]  = 8'h2C;
`endif
    exp_arr[23:16] = 8'd77;
    push(16'hFFFB, 1'b0);
    push(16'd300,  1'b0);
    push(16'd77,   1'b0);
    for (int i = 3; i < NC; i++) begin
      err_clr = (i == NC - 1);
      push(16'd0, 1'b0);
    end
    err_clr = 1'b0;
    check("quant_array", out_array, exp_arr);
    check("set_beats_clr", {79'd0, frame_err}, 80'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset mid-frame after 6 accepts
    for (int i = 0; i < 6; i++) push(16'(100 + i), 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_array", out_array,          80'd0);
    check("mid_rst_valid", {79'd0, out_valid}, 80'd0);
    check("mid_rst_ready", {79'd0, in_ready},  80'd1);
    check("mid_rst_err",   {79'd0, frame_err}, 80'd0);
    tick();
    rst_n = 1'b1;
    tick();
    exp_arr = 80'd0;
    for (int i = 0; i < NC; i++) begin
      exp_arr[i*8 +: 8] = 8'(10 * i + 5);
      push(16'(10 * i + 5), (i == NC - 1));
    end
    check("post_rst_valid", {79'd0, out_valid}, 80'd1);
    check("post_rst_array", out_array, exp_arr);
    check("post_rst_err",   {79'd0, frame_err}, 80'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
